// File: rtl/opr_pkg.sv
// Shared constants and types for the opr result capture path: widths, frame
// length, phase type and the hex-to-7-segment pattern table.
package opr_pkg;

    localparam int OPR_RESULT_W  = 4;
    localparam int OPR_FRAME_LEN = 5;
    localparam int OPR_PHASE_W   = $clog2(OPR_FRAME_LEN);

    typedef logic [OPR_PHASE_W-1:0] phase_t;

    // Segment patterns, bit order {g,f,e,d,c,b,a}, active-high; entry 15 first.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] seg_lookup(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/opr_result_fifo_hex7seg.sv
// Purely combinational nibble to 7-segment decode (active-high {g,f,e,d,c,b,a}).
module hex7seg
    import opr_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = seg_lookup(nibble_i);

endmodule

// File: rtl/opr_result_fifo.sv
// Frame-phase sampler plus FWFT FIFO for the opr result. Optional registered
// 7-segment view of the last accepted sample when OPR_RESULT_SEVSEG_EN is defined.
module opr_result_fifo
    import opr_pkg::*;
#(
    parameter int DW            = OPR_RESULT_W,
    parameter int DEPTH         = 4,
    parameter int FRAME_LEN     = OPR_FRAME_LEN,
    parameter int CAPTURE_PHASE = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [DW-1:0]            din,
    input  logic                     resync,
    output logic [DW-1:0]            out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     overflow_clr,
    output logic                     frame_pulse
`ifdef OPR_RESULT_SEVSEG_EN
    ,
    output logic [6:0]               seg
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    localparam logic [PW-1:0] LAST_PHASE = PW'(FRAME_LEN - 1);
    localparam logic [PW-1:0] CAP_PHASE  = PW'(CAPTURE_PHASE);
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [PW-1:0] PHASE_ONE  = PW'(1);

    logic [PW-1:0]            phase_q, phase_d;
    logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic [DEPTH-1:0][DW-1:0] mem_q;
    logic                     overflow_q, overflow_d;
    logic                     frame_pulse_q;

    logic capture_s, pop_s, full_s, push_s, drop_s, not_empty_s;

    // Event decode: capture, pop, and whether a capture is accepted or dropped.
    always_comb begin
        not_empty_s = (count_q != {CW{1'b0}});
        full_s      = (count_q == FULL_CNT);
        capture_s   = (phase_q == CAP_PHASE) && !resync;
        pop_s       = not_empty_s && out_ready;
        push_s      = capture_s && (!full_s || pop_s);
        drop_s      = capture_s && full_s && !pop_s;
    end

    // Next-state for phase, pointers, occupancy and sticky overflow.
    always_comb begin
        phase_d    = phase_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (resync) begin
            phase_d = {PW{1'b0}};
        end else if (phase_q == LAST_PHASE) begin
            phase_d = {PW{1'b0}};
        end else begin
            phase_d = phase_q + PHASE_ONE;
        end

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // A drop in the same cycle as a clear must leave the flag set.
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Control state registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase_q       <= {PW{1'b0}};
            wr_ptr_q      <= {AW{1'b0}};
            rd_ptr_q      <= {AW{1'b0}};
            count_q       <= {CW{1'b0}};
            overflow_q    <= 1'b0;
            frame_pulse_q <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
            frame_pulse_q <= capture_s;
        end
    end

    // FIFO storage.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_q <= '0;
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= din;
        end else begin
            mem_q <= mem_q;
        end
    end

    assign out_valid   = not_empty_s;
    assign out_data    = not_empty_s ? mem_q[rd_ptr_q] : {DW{1'b0}};
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign frame_pulse = frame_pulse_q;

`ifdef OPR_RESULT_SEVSEG_EN
    logic [6:0] seg_s;
    logic [6:0] seg_q;

    hex7seg u_hex7seg (
        .nibble_i (din[3:0]),
        .seg_o    (seg_s)
    );

    // Display follows accepted captures only; drops leave it unchanged.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            seg_q <= 7'h00;
        end else if (push_s) begin
            seg_q <= seg_s;
        end else begin
            seg_q <= seg_q;
        end
    end

    assign seg = seg_q;
`endif

endmodule

// File: tb/tb_opr_result_fifo.sv
// Self-checking bench for opr_result_fifo: directed frame scenarios followed by
// randomized traffic, all compared every cycle against a queue-based model.
module tb_opr_result_fifo;

    localparam int DW    = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 5;
    localparam int CAP   = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] din = '0;
    logic          resync = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [2:0]    count;
    logic          overflow;
    logic          overflow_clr = 1'b0;
    logic          frame_pulse;
`ifdef OPR_RESULT_SEVSEG_EN
    logic [6:0]    seg;
`endif

    int checks = 0;
    int failures = 0;

    opr_result_fifo #(.DW(DW), .DEPTH(DEPTH), .FRAME_LEN(FRAME), .CAPTURE_PHASE(CAP)) dut (
        .clock        (clock),
        .reset        (reset),
        .din          (din),
        .resync       (resync),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .count        (count),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .frame_pulse  (frame_pulse)
`ifdef OPR_RESULT_SEVSEG_EN
        ,
        .seg          (seg)
`endif
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] tb_seg(input logic [3:0] v);
        logic [6:0] pat [16];
        pat = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};
        return pat[v];
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: edges since reset/resync, a plain queue, sticky flag.
    int         m_cyc;
    int         m_q[$];
    bit         m_ovf;
    bit         m_fp;
    logic [6:0] m_seg;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_cyc = 0;
            m_q.delete();
            m_ovf = 1'b0;
            m_fp  = 1'b0;
            m_seg = 7'h00;
        end else begin
            bit cap, pop, acc, drp;
            cap = ((m_cyc % FRAME) == CAP) && !resync;
            pop = (m_q.size() > 0) && out_ready;
            acc = cap && ((m_q.size() < DEPTH) || pop);
            drp = cap && !acc;
            if (pop) void'(m_q.pop_front());
            if (acc) begin
                m_q.push_back(int'(din));
                m_seg = tb_seg(din);
            end
            if (drp) m_ovf = 1'b1;
            else if (overflow_clr) m_ovf = 1'b0;
            m_fp  = cap;
            m_cyc = resync ? 0 : m_cyc + 1;
        end
    end

    // Per-cycle comparison, sampled away from the active edge.
    always @(negedge clock) begin
        #1;
        chk("out_valid", int'(out_valid), (m_q.size() > 0) ? 1 : 0);
        chk("out_data", int'(out_data), (m_q.size() > 0) ? m_q[0] : 0);
        chk("count", int'(count), m_q.size());
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("frame_pulse", int'(frame_pulse), int'(m_fp));
`ifdef OPR_RESULT_SEVSEG_EN
        chk("seg", int'(seg), int'(m_seg));
`endif
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            @(negedge clock);
            #2;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(2);
        reset = 1'b1;
    endtask

    initial begin
        din = 4'h7;
        step(2);
        chk("lit_reset_valid", int'(out_valid), 0);
        chk("lit_reset_count", int'(count), 0);
        reset = 1'b1;

        // First capture lands on edge 5 after release.
        step(4);
        chk("lit_pre_cap_valid", int'(out_valid), 0);
        step(1);
        chk("lit_cap_valid", int'(out_valid), 1);
        chk("lit_cap_data", int'(out_data), 7);
        chk("lit_cap_count", int'(count), 1);
        chk("lit_cap_pulse", int'(frame_pulse), 1);
        step(1);
        chk("lit_pulse_low", int'(frame_pulse), 0);

        // Fill with 1..4, then drop 5.
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            din = 4'(k);
            step(5);
            if (k == 4) begin
                chk("lit_full_count", int'(count), 4);
                chk("lit_full_head", int'(out_data), 1);
                chk("lit_full_ovf", int'(overflow), 0);
            end
        end
        chk("lit_drop_count", int'(count), 4);
        chk("lit_drop_head", int'(out_data), 1);
        chk("lit_drop_ovf", int'(overflow), 1);

        // Simultaneous pop and push while full.
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            din = 4'(k);
            step(5);
        end
        din = 4'h5;
        step(4);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        chk("lit_pp_count", int'(count), 4);
        chk("lit_pp_head", int'(out_data), 2);
        chk("lit_pp_ovf", int'(overflow), 0);

        // Clear coincident with a drop loses; a later quiet clear wins.
        din = 4'h6;
        step(4);
        overflow_clr = 1'b1;
        step(1);
        overflow_clr = 1'b0;
        chk("lit_clr_drop_ovf", int'(overflow), 1);
        step(1);
        overflow_clr = 1'b1;
        step(1);
        overflow_clr = 1'b0;
        chk("lit_clr_quiet_ovf", int'(overflow), 0);

        // Resync at phase 3, next capture five edges later.
        do_reset();
        din = 4'hA;
        step(3);
        resync = 1'b1;
        step(1);
        resync = 1'b0;
        step(4);
        chk("lit_resync_no_cap", int'(count), 0);
        step(1);
        chk("lit_resync_cap", int'(count), 1);
        chk("lit_resync_data", int'(out_data), 10);
`ifdef OPR_RESULT_SEVSEG_EN
        chk("lit_seg_a", int'(seg), 7'b1110111);
`endif
        step(2);
        reset = 1'b0;
        #1;
        chk("lit_mid_rst_count", int'(count), 0);
        chk("lit_mid_rst_valid", int'(out_valid), 0);
`ifdef OPR_RESULT_SEVSEG_EN
        chk("lit_mid_rst_seg", int'(seg), 0);
`endif
        step(1);
        reset = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            din          = 4'($urandom_range(0, 15));
            out_ready    = ($urandom_range(0, 2) == 0);
            resync       = ($urandom_range(0, 29) == 0);
            overflow_clr = ($urandom_range(0, 19) == 0);
            reset        = ($urandom_range(0, 299) != 0);
            step(1);
        end
        reset = 1'b1;
        resync = 1'b0;
        overflow_clr = 1'b0;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
